muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// A request is accepted on a rising edge with start=1 and busy=0. Multiply-
// and divide-class operations then run for a fixed number of cycles.
// HI/LO are written only when that count runs out, and done pulses for
// one cycle after the write. MTHI/MTLO write HI/LO directly at the
// accept edge.
//
// Parameters:
//   WIDTH        operand and HI/LO width (>= 8)
//   MULT_CYCLES  busy length of multiply-class operations (>= 1)
//   DIV_CYCLES   busy length of divide operations (>= 1)
//
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous active-high reset
//   start  in   1      request to execute op
//   op     in   4      0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                      7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (7-10 need macro)
//   a      in   WIDTH  operand A (rs), source for MTHI/MTLO
//   b      in   WIDTH  operand B (rt)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse after HI/LO commit
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
//
// Optional feature:
//   Define MULDIV_MACC_EN to enable the multiply-accumulate operations
//   MADD/MADDU/MSUB/MSUBU. When the macro is undefined, ops 7-10 behave as
//   NOP and no accumulate logic is built.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic                    w_is_mul;
    logic                    w_is_div;
    logic [2*WIDTH-1:0]      w_a_sx;
    logic [2*WIDTH-1:0]      w_b_sx;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0]      w_prod_u;
    logic [2*WIDTH-1:0]      w_div_s;
    logic [2*WIDTH-1:0]      w_div_u;
`ifdef MULDIV_MACC_EN
    logic [2*WIDTH-1:0]      w_acc;
`endif

    // Signed divide built on magnitudes: quotient truncates toward zero and
    // the remainder follows the dividend's sign. The most-negative / -1 case
    // falls out naturally: the magnitude 2^(WIDTH-1) negates back to the
    // most-negative value and the remainder is zero. Returns {rem, quot}.
    function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] n,
                                                      input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] n_mag;
        logic [WIDTH-1:0] d_mag;
        logic [WIDTH-1:0] q_mag;
        logic [WIDTH-1:0] r_mag;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        n_mag = n[WIDTH-1] ? -n : n;
        d_mag = d[WIDTH-1] ? -d : d;
        q_mag = n_mag / d_mag;
        r_mag = n_mag % d_mag;
        q     = (n[WIDTH-1] ^ d[WIDTH-1]) ? -q_mag : q_mag;
        r     = n[WIDTH-1] ? -r_mag : r_mag;
        return {r, q};
    endfunction

`ifdef MULDIV_MACC_EN
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
                      (op == OP_MADD) || (op == OP_MADDU) ||
                      (op == OP_MSUB) || (op == OP_MSUBU);
`else
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Products are formed at double width from extended operands; the low
    // 2*WIDTH bits of the extended product are the exact result.
    assign w_a_sx   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_b_sx   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_s = $signed(w_a_sx * w_b_sx);
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_div_s  = div_signed(r_a, r_b);
    assign w_div_u  = {r_a % r_b, r_a / r_b};
`ifdef MULDIV_MACC_EN
    assign w_acc    = {r_hi, r_lo};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_op   <= 4'd0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_cnt != '0) begin
                // Running: new requests are ignored; commit on the 1->0 step.
                r_cnt  <= r_cnt - CNT_ONE;
                r_busy <= (r_cnt != CNT_ONE);
                if (r_cnt == CNT_ONE) begin
                    r_done <= 1'b1;
                    case (r_op)
                        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                        // A zero divisor leaves HI/LO untouched.
                        OP_DIV:   if (r_b != '0) {r_hi, r_lo} <= w_div_s;
                        OP_DIVU:  if (r_b != '0) {r_hi, r_lo} <= w_div_u;
`ifdef MULDIV_MACC_EN
                        OP_MADD:  {r_hi, r_lo} <= w_acc + w_prod_s;
                        OP_MADDU: {r_hi, r_lo} <= w_acc + w_prod_u;
                        OP_MSUB:  {r_hi, r_lo} <= w_acc - w_prod_s;
                        OP_MSUBU: {r_hi, r_lo} <= w_acc - w_prod_u;
`endif
                        default: ;
                    endcase
                end
            end else if (start) begin
                if (w_is_mul) begin
                    r_cnt  <= CNT_MUL;
                    r_busy <= 1'b1;
                    r_op   <= op;
                    r_a    <= a;
                    r_b    <= b;
                end else if (w_is_div) begin
                    r_cnt  <= CNT_DIV;
                    r_busy <= 1'b1;
                    r_op   <= op;
                    r_a    <= a;
                    r_b    <= b;
                end else if (op == OP_MTHI) begin
                    r_hi <= a;
                end else if (op == OP_MTLO) begin
                    r_lo <= a;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] sb_q[$];
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model for ops 1-4, used to build expectations for random ops.
    function automatic void model(input logic [3:0] f_op, input logic [W-1:0] f_a,
                                  input logic [W-1:0] f_b, output logic [W-1:0] o_hi,
                                  output logic [W-1:0] o_lo, output int o_n);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          si;
        int          sj;
        o_hi = m_hi;
        o_lo = m_lo;
        o_n  = 0;
        case (f_op)
            4'd1: begin
                sa = $signed(f_a);
                sb = $signed(f_b);
                p  = sa * sb;
                {o_hi, o_lo} = p;
                o_n = 5;
            end
            4'd2: begin
                p = {32'b0, f_a} * {32'b0, f_b};
                {o_hi, o_lo} = p;
                o_n = 5;
            end
            4'd3: begin
                o_n = 10;
                if (f_b != 0) begin
                    if (f_a == 32'h80000000 && f_b == 32'hFFFFFFFF) begin
                        o_lo = f_a;
                        o_hi = 0;
                    end else begin
                        si = $signed(f_a);
                        sj = $signed(f_b);
                        o_lo = si / sj;
                        o_hi = si % sj;
                    end
                end
            end
            4'd4: begin
                o_n = 10;
                if (f_b != 0) begin
                    o_lo = f_a / f_b;
                    o_hi = f_a % f_b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue a multi-cycle op at the current falling edge and follow it to done.
    // inject > 0 drives an MTLO request in that busy cycle (must be ignored).
    task automatic do_op(input string tag, input logic [3:0] f_op, input logic [W-1:0] f_a,
                         input logic [W-1:0] f_b, input logic [W-1:0] e_hi,
                         input logic [W-1:0] e_lo, input int e_n, input int inject);
        logic [2*W-1:0] exp;
        int             cnt;
        sb_q.push_back({e_hi, e_lo});
        start = 1'b1; op = f_op; a = f_a; b = f_b;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, "_done_low_in_busy"}, 64'(done), 64'd0);
        check({tag, "_hilo_held"}, {hi, lo}, {m_hi, m_lo});
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == inject) begin
                start = 1'b1; op = 4'd6; a = 32'hDEADBEEF;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; op = 4'd0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(e_n));
        check({tag, "_done_pulse"}, 64'(done), 64'd1);
        exp = sb_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, exp);
        {m_hi, m_lo} = exp;
    endtask

    task automatic do_move(input string tag, input logic [3:0] f_op, input logic [W-1:0] f_a);
        start = 1'b1; op = f_op; a = f_a;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        if (f_op == 4'd5) m_hi = f_a; else m_lo = f_a;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic do_ignored(input string tag, input logic [3:0] f_op);
        start = 1'b1; op = f_op; a = 32'h00000001; b = 32'h00000001;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_busy_later"}, 64'(busy | done), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
        logic [3:0]   r_op;
        int           e_n;
        logic         seen;

        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0);
        do_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 0);
        do_op("div_neg7_2", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
        do_op("div_7_neg2", 4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 0);
        do_op("divu_by0", 4'd4, 32'd7, 32'd0, m_hi, m_lo, 10, 0);
        do_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0);
        do_op("divu_100_7", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0);

        do_move("mthi", 4'd5, 32'h12345678);
        do_op("mtlo_in_busy", 4'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5, 2);
        do_move("mtlo", 4'd6, 32'hCAFEF00D);

        do_ignored("nop", 4'd0);
        do_ignored("op15", 4'd15);

        do_move("macc_pre_hi", 4'd5, 32'h00000000);
        do_move("macc_pre_lo", 4'd6, 32'hFFFFFFFF);
`ifdef MULDIV_MACC_EN
        do_op("maddu", 4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
        do_op("msub", 4'd9, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, 5, 0);
`else
        do_ignored("maddu_off", 4'd8);
        do_ignored("msub_off", 4'd9);
`endif

        for (int i = 0; i < 8; i++) begin
            r_op = 4'(1 + ($urandom % 4));
            r_a  = $urandom;
            r_b  = (i % 3 == 0) ? ($urandom % 8) : $urandom;
            model(r_op, r_a, r_b, e_hi, e_lo, e_n);
            do_op("random", r_op, r_a, r_b, e_hi, e_lo, e_n, 0);
        end

        // Abort a long multiply with reset in its third busy cycle.
        start = 1'b1; op = 4'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        do_move("post_abort_mthi", 4'd5, 32'h0000BEEF);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd3;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; op = 4'd0;
        m_hi = '0; m_lo = '0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("rst_prio_hilo", {hi, lo}, {m_hi, m_lo});
        check("rst_prio_busy_later", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
